// File: rtl/ar9331_gpio_rx.sv
// Byte-wide GPIO frame receiver for the AR9331 link: synchronizes the pins,
// acks each byte by toggling gpio_ack and buffers bytes in a small FIFO.
module ar9331_gpio_rx #(
  parameter int unsigned MAX_LEN = 68,
  parameter int unsigned DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gpio_frame,
  input  logic       gpio_strobe,
  input  logic [7:0] gpio_data,
  output logic       gpio_ack,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       frame_done,
  output logic [7:0] frame_len,
  output logic       frame_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [7:0] MAX_B = MAX_LEN[7:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_STORE,
    S_ACK,
    S_END
  } state_t;

  state_t      state_q, state_d;
  logic        frame_s1_q, frame_s1_d, frame_s2_q, frame_s2_d;
  logic        frame_dl_q, frame_dl_d;
  logic        strb_s1_q, strb_s1_d, strb_s2_q, strb_s2_d;
  logic        strb_dl_q, strb_dl_d;
  logic [7:0]  data_s1_q, data_s1_d, data_s2_q, data_s2_d;
  logic [1:0]  settle_q, settle_d;
  logic [7:0]  byte_q, byte_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        ack_q, ack_d;
  logic        done_q, done_d;
  logic [7:0]  len_q, len_d;
  logic        ferr_q, ferr_d;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];
  logic        full, empty, push, pop, rise;

  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = (wr_q == rd_q);
  assign pop   = !empty && m_ready;
  // the synchronizer needs a few cycles to reflect the pin after reset,
  // so a frame already in flight is not mistaken for a new rise
  assign rise  = frame_s2_q && !frame_dl_q && (settle_q == 2'd3);

  assign gpio_ack   = ack_q;
  assign m_valid    = !empty;
  assign m_data     = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
  assign frame_done = done_q;
  assign frame_len  = len_q;
  assign frame_err  = ferr_q;

  always_comb begin
    state_d    = state_q;
    frame_s1_d = gpio_frame;
    frame_s2_d = frame_s1_q;
    frame_dl_d = frame_s2_q;
    strb_s1_d  = gpio_strobe;
    strb_s2_d  = strb_s1_q;
    strb_dl_d  = strb_dl_q;
    data_s1_d  = gpio_data;
    data_s2_d  = data_s1_q;
    settle_d   = settle_q;
    byte_d     = byte_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    ack_d      = ack_q;
    done_d     = 1'b0;
    len_d      = len_q;
    ferr_d     = ferr_q;
    push       = 1'b0;
    if (settle_q != 2'd3) settle_d = settle_q + 2'd1;
    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d   = S_WAIT;
          cnt_d     = 8'h00;
          err_d     = 1'b0;
          strb_dl_d = strb_s2_q;
        end
      end
      S_WAIT: begin
        if (strb_s2_q != strb_dl_q) begin
          strb_dl_d = strb_s2_q;
          byte_d    = data_s2_q;
          state_d   = S_STORE;
        end else if (!frame_s2_q) begin
          state_d = S_END;
        end
      end
      S_STORE: begin
        if (!frame_s2_q) begin
          err_d   = 1'b1;
          state_d = S_END;
        end else if (cnt_q >= MAX_B) begin
          err_d   = 1'b1;
          state_d = S_ACK;
        end else if (!full) begin
          push    = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        ack_d = ~ack_q;
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        state_d = frame_s2_q ? S_WAIT : S_END;
      end
      S_END: begin
        done_d  = 1'b1;
        len_d   = cnt_q;
        ferr_d  = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q[AW-1:0]] = byte_q;
    wr_d = wr_q + (AW+1)'(push);
    rd_d = rd_q + (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      frame_s1_q <= 1'b0;
      frame_s2_q <= 1'b0;
      frame_dl_q <= 1'b0;
      strb_s1_q  <= 1'b0;
      strb_s2_q  <= 1'b0;
      strb_dl_q  <= 1'b0;
      data_s1_q  <= 8'h00;
      data_s2_q  <= 8'h00;
      settle_q   <= 2'd0;
      byte_q     <= 8'h00;
      cnt_q      <= 8'h00;
      err_q      <= 1'b0;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      len_q      <= 8'h00;
      ferr_q     <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      mem_q      <= '{default: 8'h00};
    end else begin
      state_q    <= state_d;
      frame_s1_q <= frame_s1_d;
      frame_s2_q <= frame_s2_d;
      frame_dl_q <= frame_dl_d;
      strb_s1_q  <= strb_s1_d;
      strb_s2_q  <= strb_s2_d;
      strb_dl_q  <= strb_dl_d;
      data_s1_q  <= data_s1_d;
      data_s2_q  <= data_s2_d;
      settle_q   <= settle_d;
      byte_q     <= byte_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      len_q      <= len_d;
      ferr_q     <= ferr_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: doc/ar9331_gpio_rx.md
AR9331_GPIO_RX -- requirements
Module: ar9331_gpio_rx

Parameters
REQ-001 SHALL provide MAX_LEN, default 68 (8'h44): maximum bytes stored per frame.
REQ-002 SHALL provide DEPTH, default 4 (power of two, 2..16): output FIFO depth in bytes.

Interface
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 gpio_frame  input  1  asynchronous; high for the duration of a frame from the AR9331.
REQ-006 gpio_strobe  input  1  asynchronous; toggles once per new byte on gpio_data.
REQ-007 gpio_data  input  8  asynchronous; byte held stable by the sender until gpio_ack toggles.
REQ-008 gpio_ack  output  1  toggles once per byte consumed.
REQ-009 m_data  output  8  FIFO head byte.
REQ-010 m_valid  output  1  FIFO non-empty.
REQ-011 m_ready  input  1  downstream accept; a pop occurs when m_valid && m_ready.
REQ-012 frame_done  output  1  one-cycle pulse at frame end.
REQ-013 frame_len  output  8  bytes received in the last frame, saturating at 255; valid from frame_done onward.
REQ-014 frame_err  output  1  error flag for the last frame; valid from frame_done onward.

Function
REQ-015 gpio_frame, gpio_strobe and gpio_data SHALL each pass through a 2-flop synchronizer; all logic SHALL use only the synchronized copies.
REQ-016 A strobe event SHALL be the synchronized strobe differing from its one-cycle-delayed copy (strobe_d).
REQ-017 The FSM SHALL have the states IDLE, WAIT_BYTE, STORE, ACK and END.
REQ-018 IDLE: on a synchronized gpio_frame rise, go to WAIT_BYTE, clear the byte count and the error flag, and load strobe_d from the current synchronized strobe.
REQ-019 WAIT_BYTE: on a strobe event, latch the synchronized gpio_data and go to STORE.
REQ-020 WAIT_BYTE: if gpio_frame falls, go to END.
REQ-021 STORE: if the count is below MAX_LEN and the FIFO is not full, write the byte and go to ACK.
REQ-022 STORE: if the count is at or above MAX_LEN, drop the byte, set the error flag and go to ACK.
REQ-023 STORE: if the count is below MAX_LEN and the FIFO is full, stay in STORE (backpressure: no ack).
REQ-024 ACK: toggle gpio_ack, increment the count (saturating at 255) and return to WAIT_BYTE.
REQ-025 Latency: gpio_ack SHALL toggle 5 clk cycles after the gpio_strobe pin toggle when the FIFO has space, and m_valid SHALL rise no later than the cycle in which gpio_ack toggles.
REQ-026 A gpio_frame fall while in STORE SHALL discard the pending byte, set the error flag, skip the ack and go to END.
REQ-027 A gpio_frame fall while in ACK SHALL complete the ack first, then go to END.
REQ-028 END: pulse frame_done for one cycle, update frame_len and frame_err, then go to IDLE.
REQ-029 Strobe events outside a frame (IDLE) SHALL be ignored, with no ack.
REQ-030 FIFO: a write and a pop in the same cycle SHALL be allowed whenever the FIFO is not full, leaving the occupancy unchanged.
REQ-031 FIFO: the full check SHALL use registered state only; a same-cycle pop SHALL NOT enable a write when the FIFO is full.
REQ-032 FIFO pointers SHALL wrap modulo DEPTH.
REQ-033 A pop when the FIFO is empty SHALL be ignored.
REQ-034 m_data SHALL be stable while m_valid is high and m_ready is low.
REQ-035 FIFO contents SHALL persist across frames; a new frame SHALL NOT flush the FIFO.

Reset
REQ-036 rst SHALL force the state to IDLE and set gpio_ack=0, m_valid=0, m_data=0, frame_done=0, frame_len=0 and frame_err=0.
REQ-037 rst SHALL empty the FIFO, clear the synchronizers, strobe_d and the byte count.
REQ-038 rst asserted mid-frame SHALL abort the frame without a frame_done pulse; after release, receive SHALL resume only on the next gpio_frame rise.

Verification
REQ-039 Frame of 3 bytes (0x01, 0x02, 0x03), m_ready=1 -> three gpio_ack toggles, m_data sequence 01,02,03, frame_done with frame_len=3 and frame_err=0.
REQ-040 Frame of 68 bytes (0x00..0x43), m_ready=1 -> 68 acks, bytes popped in order, frame_len=68, frame_err=0.
REQ-041 Frame of 70 bytes -> 70 acks, 68 bytes stored, frame_len=70, frame_err=1.
REQ-042 m_ready=0, 6 bytes sent (DEPTH=4) -> exactly 4 acks; raising m_ready -> the remaining 2 acks follow and all 6 bytes pop in order.
REQ-043 gpio_frame dropped 1 cycle after a strobe toggle (pending in STORE, FIFO full) -> no ack for that byte, frame_err=1, frame_done pulses.
REQ-044 rst pulse after byte 2 of a frame -> gpio_ack=0, m_valid=0, no frame_done; a subsequent new frame is received cleanly.
